alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready handshake on both sides.
// Single-edge ops (ADD, SUB, XOR, ORR, RXR, undefined) reach DONE one edge
// after acceptance; LSH/RSH shift one bit per BUSY cycle; MUL is an
// iterative unsigned shift-add over W BUSY cycles.
// Optional feature macro: ALU_SEQ_MUL_EN enables the multiplier (opcode 7).
// When it is undefined, opcode 7 behaves as an undefined opcode and no
// multiplier datapath exists.
module alu_seq #(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  input  logic [Ops-1:0] OP,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   Out,
  output logic [W-1:0]   OutHi,
  output logic           Zero,
  output logic           Carry,
  output logic           Parity,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int CW = $clog2(W + 1);

  localparam logic [Ops-1:0] OP_ADD = Ops'(0);
  localparam logic [Ops-1:0] OP_LSH = Ops'(1);
  localparam logic [Ops-1:0] OP_RSH = Ops'(2);
  localparam logic [Ops-1:0] OP_XOR = Ops'(3);
  localparam logic [Ops-1:0] OP_RXR = Ops'(4);
  localparam logic [Ops-1:0] OP_SUB = Ops'(5);
  localparam logic [Ops-1:0] OP_ORR = Ops'(6);
`ifdef ALU_SEQ_MUL_EN
  localparam logic [Ops-1:0] OP_MUL = Ops'(7);
`endif

  localparam logic [W-1:0]  W_VAL  = W'(W);
  localparam logic [CW-1:0] CNT_W  = CW'(W);
  localparam logic [CW-1:0] CNT_1  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Even parity of a result word, used for the Parity flag.
  function automatic logic parity_f(input logic [W-1:0] v);
    return ^v;
  endfunction

  state_t         state_r;
  logic [Ops-1:0] op_r;
  logic [W-1:0]   work_r;      // shift register / multiplier bits
  logic [CW-1:0]  cnt_r;
  logic [W-1:0]   out_r;
  logic [W-1:0]   outhi_r;
  logic           zero_r;
  logic           carry_r;
  logic           parity_r;
  logic           out_valid_r;
  logic           in_ready_r;

  logic [W-1:0]   res_s;
  logic           carry_s;
  logic [W:0]     sum_s;
  logic           is_shift_s;
  logic [W-1:0]   shift_next_s;

`ifdef ALU_SEQ_MUL_EN
  logic [W-1:0]   a_r;         // multiplicand
  logic [W-1:0]   acc_r;       // high half of the partial product
  logic [W:0]     madd_s;
  logic [W-1:0]   acc_next_s;
  logic [W-1:0]   lo_next_s;
`endif

  // Single-edge result and carry computed straight from the inputs.
  always_comb begin
    res_s   = '0;
    carry_s = 1'b0;
    sum_s   = '0;
    case (OP)
      OP_ADD: begin
        sum_s   = {1'b0, InputA} + {1'b0, InputB};
        res_s   = sum_s[W-1:0];
        carry_s = sum_s[W];
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1 is the "no borrow" indication.
        sum_s   = {1'b0, InputA} + {1'b0, ~InputB} + {{W{1'b0}}, 1'b1};
        res_s   = sum_s[W-1:0];
        carry_s = sum_s[W];
      end
      OP_XOR:  res_s = InputA ^ InputB;
      OP_ORR:  res_s = InputA | InputB;
      OP_RXR:  res_s = {{(W-1){1'b0}}, ^InputA};
      OP_LSH,
      OP_RSH:  res_s = InputA;   // only reaches DONE directly when B == 0
      default: res_s = '0;
    endcase
  end

  // Opcode class decode and one-bit shift step.
  always_comb begin
    is_shift_s = (OP == OP_LSH) || (OP == OP_RSH);
    if (op_r == OP_LSH) begin
      shift_next_s = {work_r[W-2:0], 1'b0};
    end else begin
      shift_next_s = {1'b0, work_r[W-1:1]};
    end
  end

`ifdef ALU_SEQ_MUL_EN
  // One shift-add step: add the multiplicand when the current multiplier
  // bit is set, then shift the {acc, multiplier} pair right by one.
  always_comb begin
    if (work_r[0]) begin
      madd_s = {1'b0, acc_r} + {1'b0, a_r};
    end else begin
      madd_s = {1'b0, acc_r};
    end
    acc_next_s = madd_s[W:1];
    lo_next_s  = {madd_s[0], work_r[W-1:1]};
  end
`endif

  // Control FSM with all result, flag and handshake registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r     <= IDLE;
      op_r        <= '0;
      work_r      <= '0;
      cnt_r       <= '0;
      out_r       <= '0;
      outhi_r     <= '0;
      zero_r      <= 1'b1;
      carry_r     <= 1'b0;
      parity_r    <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
      a_r         <= '0;
      acc_r       <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r       <= OP;
            work_r     <= InputA;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            if (is_shift_s && (InputB != '0)) begin
              state_r <= BUSY;
              cnt_r   <= (InputB >= W_VAL) ? CNT_W : CW'(InputB);
            end
`ifdef ALU_SEQ_MUL_EN
            else if (OP == OP_MUL) begin
              state_r <= BUSY;
              a_r     <= InputA;
              work_r  <= InputB;
              acc_r   <= '0;
              cnt_r   <= CNT_W;
            end
`endif
            else begin
              state_r     <= DONE;
              out_r       <= res_s;
              outhi_r     <= '0;
              zero_r      <= (res_s == '0);
              carry_r     <= carry_s;
              parity_r    <= parity_f(res_s);
              out_valid_r <= 1'b1;
            end
          end
        end
        BUSY: begin
          cnt_r <= cnt_r - CNT_1;
`ifdef ALU_SEQ_MUL_EN
          if (op_r == OP_MUL) begin
            acc_r  <= acc_next_s;
            work_r <= lo_next_s;
            if (cnt_r == CNT_1) begin
              state_r     <= DONE;
              out_r       <= lo_next_s;
              outhi_r     <= acc_next_s;
              zero_r      <= (lo_next_s == '0);
              carry_r     <= 1'b0;
              parity_r    <= parity_f(lo_next_s);
              out_valid_r <= 1'b1;
            end
          end else
`endif
          begin
            work_r <= shift_next_s;
            if (cnt_r == CNT_1) begin
              state_r     <= DONE;
              out_r       <= shift_next_s;
              outhi_r     <= '0;
              zero_r      <= (shift_next_s == '0);
              carry_r     <= 1'b0;
              parity_r    <= parity_f(shift_next_s);
              out_valid_r <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign Out       = out_r;
  assign OutHi     = outhi_r;
  assign Zero      = zero_r;
  assign Carry     = carry_r;
  assign Parity    = parity_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (W=8). Expected results come from a
// behavioural model and travel through a scoreboard queue.
module tb_alu_seq;

  localparam int W   = 8;
  localparam int Ops = 4;

  logic           Clk = 1'b0;
  logic           Reset;
  logic [W-1:0]   InputA;
  logic [W-1:0]   InputB;
  logic [Ops-1:0] OP;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   Out;
  logic [W-1:0]   OutHi;
  logic           Zero;
  logic           Carry;
  logic           Parity;
  logic           out_valid;
  logic           out_ready;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic         z;
    logic         c;
    logic         p;
    logic [7:0]   lat;
  } exp_t;

  exp_t sb[$];

  alu_seq #(.W(W), .Ops(Ops)) dut (
    .Clk(Clk), .Reset(Reset), .InputA(InputA), .InputB(InputB), .OP(OP),
    .in_valid(in_valid), .in_ready(in_ready), .Out(Out), .OutHi(OutHi),
    .Zero(Zero), .Carry(Carry), .Parity(Parity), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: direct arithmetic, not an iterative datapath.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [Ops-1:0] op);
    exp_t e;
    logic [W:0]     s;
    logic [2*W-1:0] prod;
    int k;
    e = '0;
    e.lat = 8'd1;
    k = (b >= W) ? W : int'(b);
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; e.out = s[W-1:0]; e.c = s[W]; end
      4'd5: begin e.out = a - b; e.c = (a >= b); end
      4'd1: begin e.out = (k >= W) ? '0 : (a << k); e.lat = 8'(1 + k); end
      4'd2: begin e.out = (k >= W) ? '0 : (a >> k); e.lat = 8'(1 + k); end
      4'd3: e.out = a ^ b;
      4'd6: e.out = a | b;
      4'd4: e.out = {{(W-1){1'b0}}, ^a};
`ifdef ALU_SEQ_MUL_EN
      4'd7: begin prod = a * b; e.out = prod[W-1:0]; e.hi = prod[2*W-1:W]; e.lat = 8'(1 + W); end
`endif
      default: e.out = '0;
    endcase
    e.z = (e.out == '0);
    e.p = ^e.out;
    return e;
  endfunction

  // Drive one request for a single edge and push its expected result.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [Ops-1:0] op);
    InputA = a; InputB = b; OP = op; in_valid = 1'b1;
    sb.push_back(model(a, b, op));
    @(posedge Clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, then pop and compare every field.
  task automatic wait_result(input string tag);
    exp_t e;
    int lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, 32'(lat), 32'(e.lat));
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_Out"}, 32'(Out), 32'(e.out));
      check({tag, "_OutHi"}, 32'(OutHi), 32'(e.hi));
      check({tag, "_Zero"}, 32'(Zero), 32'(e.z));
      check({tag, "_Carry"}, 32'(Carry), 32'(e.c));
      check({tag, "_Parity"}, 32'(Parity), 32'(e.p));
      check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic [Ops-1:0] op);
    start_op(a, b, op);
    wait_result(tag);
    release_result(tag);
  endtask

  initial begin
    logic [W-1:0] held_out;
    logic         held_z, held_c, held_p;
    int           seen;

    Reset = 1'b0; InputA = '0; InputB = '0; OP = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_Out", 32'(Out), 32'd0);
    check("rst_OutHi", 32'(OutHi), 32'd0);
    check("rst_Zero", 32'(Zero), 32'd1);
    check("rst_Carry", 32'(Carry), 32'd0);
    check("rst_Parity", 32'(Parity), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_op("add_f0_20", 8'hF0, 8'h20, 4'd0);
    run_op("sub_5_5",   8'h05, 8'h05, 4'd5);
    run_op("sub_3_5",   8'h03, 8'h05, 4'd5);
    run_op("lsh_81_3",  8'h81, 8'h03, 4'd1);
    run_op("rsh_ff_9",  8'hFF, 8'h09, 4'd2);
    run_op("rsh_b6_0",  8'hB6, 8'h00, 4'd2);
    run_op("lsh_01_8",  8'h01, 8'h08, 4'd1);
    run_op("lsh_c3_7",  8'hC3, 8'h07, 4'd1);
    run_op("xor",       8'hA5, 8'h3C, 4'd3);
    run_op("orr",       8'h50, 8'h05, 4'd6);
    run_op("rxr_odd",   8'h07, 8'h00, 4'd4);
    run_op("rxr_even",  8'h03, 8'hFF, 4'd4);
    run_op("undef_9",   8'h12, 8'h34, 4'd9);
    run_op("mul_ff_ff", 8'hFF, 8'hFF, 4'd7);
    run_op("mul_0d_0b", 8'h0D, 8'h0B, 4'd7);
    run_op("add_ff_01", 8'hFF, 8'h01, 4'd0);

    // Backpressure: result held while out_ready is low, new requests ignored.
    start_op(8'h21, 8'h11, 4'd0);
    wait_result("bp");
    held_out = Out; held_z = Zero; held_c = Carry; held_p = Parity;
    InputA = 8'h77; InputB = 8'h01; OP = 4'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check("bp_Out_stable", 32'(Out), 32'(held_out));
      check("bp_flags_stable", {29'd0, Zero, Carry, Parity}, {29'd0, held_z, held_c, held_p});
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid_high", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    release_result("bp");
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      if (out_valid) seen++;
    end
    check("bp_no_phantom_result", 32'(seen), 32'd0);

    // Reset in the middle of a MUL: operation abandoned, no result ever shown.
    InputA = 8'hFF; InputB = 8'hFF; OP = 4'd7; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge Clk); #1;
    end
    #2 Reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_Out", 32'(Out), 32'd0);
    check("midrst_OutHi", 32'(OutHi), 32'd0);
    #2 Reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    run_op("add_1_1", 8'h01, 8'h01, 4'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
